// File: rtl/tinyalu_if.sv
// tinyalu_if -- request/response bundle between the ALU driver and tinyalu.
//   A, B    : 8-bit unsigned operands (driver -> ALU)
//   op      : 3-bit opcode (driver -> ALU)
//   start   : request, held with A/B/op until done or abandonment (driver -> ALU)
//   done    : one-cycle completion pulse (ALU -> driver)
//   result  : 16-bit result, held until the next completion (ALU -> driver)
interface tinyalu_if;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;

  modport master (output A, B, op, start, input done, result);
  modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu.sv
// tinyalu -- multi-cycle 8-bit ALU with a start/done handshake.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears state and all registers
//   bus     : tinyalu_if.slave (A, B, op, start in; done, result out)
// add/and/xor complete on the accepting edge; mul latches its operands and
// finishes two edges later. RELEASE absorbs a held start so that each request
// produces exactly one done pulse.
module tinyalu (
  input  logic       clk,
  input  logic       reset_n,
  tinyalu_if.slave   bus
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, RELEASE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] prod;
  logic        ld_alu;
  logic        ld_mul;
  logic        ld_ops;
  logic        ld_prod;

  // Single-cycle ops on the live operands; results are zero-extended to 16 bits.
  function automatic logic [15:0] alu_fn(input logic [2:0] f,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] r;
    r = 16'h0000;
    case (f)
      OP_ADD:  r = {8'h00, a} + {8'h00, b};
      OP_AND:  r = {8'h00, a & b};
      OP_XOR:  r = {8'h00, a ^ b};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    ld_alu    = 1'b0;
    ld_mul    = 1'b0;
    ld_ops    = 1'b0;
    ld_prod   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_ADD, OP_AND, OP_XOR: begin
              ld_alu    = 1'b1;
              state_nxt = RELEASE;
            end
            OP_MUL: begin
              ld_ops    = 1'b1;
              state_nxt = MUL1;
            end
            default: state_nxt = IDLE;  // no_op and illegal codes are ignored
          endcase
        end
      end
      MUL1: begin
        if (bus.start) begin
          ld_prod   = 1'b1;
          state_nxt = MUL2;
        end else begin
          state_nxt = IDLE;  // driver abandoned the multiply
        end
      end
      MUL2: begin
        if (bus.start) begin
          ld_mul    = 1'b1;
          state_nxt = RELEASE;
        end else begin
          state_nxt = IDLE;
        end
      end
      RELEASE: begin
        if (!bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      prod       <= 16'h0000;
      bus.done   <= 1'b0;
      bus.result <= 16'h0000;
    end else begin
      state    <= state_nxt;
      bus.done <= ld_alu | ld_mul;
      // Stage 0: operand capture at acceptance; later operand changes are ignored
      if (ld_ops) begin
        a_q <= bus.A;
        b_q <= bus.B;
      end
      // Stage 1: full 16-bit unsigned product
      if (ld_prod) prod <= {8'h00, a_q} * {8'h00, b_q};
      // Stage 2: result register, written only alongside a done pulse
      if (ld_alu)      bus.result <= alu_fn(bus.op, bus.A, bus.B);
      else if (ld_mul) bus.result <= prod;
    end
  end

endmodule

// File: tb/tb_tinyalu.sv
// tb_tinyalu -- directed test of tinyalu against a transaction-level model.
// Each request computes its expected value with plain arithmetic and the edge
// at which done must appear; a per-cycle compare process checks done/result.
module tb_tinyalu;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tinyalu_if bus();

  tinyalu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  // Model state: the single outstanding completion and the held result.
  int          sched_edge = -1;
  logic [15:0] sched_val  = 16'h0000;
  logic [15:0] model_res  = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] o,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
    int r;
    case (o)
      3'd1:    r = int'(a) + int'(b);
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a ^ b);
      3'd4:    r = int'(a) * int'(b);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // Per-cycle compare, sampling on the falling edge.
  initial begin
    logic exp_done;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_done  = 1'b0;
        model_res = 16'h0000;
      end else if (edge_n == sched_edge) begin
        exp_done  = 1'b1;
        model_res = sched_val;
      end else begin
        exp_done = 1'b0;
      end
      chk("cyc_done", {31'b0, bus.done}, {31'b0, exp_done});
      chk("cyc_result", {16'b0, bus.result}, {16'b0, model_res});
    end
  end

  // One request. extra: cycles to keep start high beyond the done cycle
  // (for ignored opcodes: total cycles high). abort_at: 1 drops start while
  // in MUL1, 2 while in MUL2, 0 never. change_a flips A after acceptance.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int extra, input int abort_at, input bit change_a);
    int  k;
    int  lat;
    int  n;
    bit  legal;
    @(negedge clk);
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    k     = edge_n + 1;
    legal = (o >= 3'd1) && (o <= 3'd4);
    lat   = (o == 3'd4) ? 2 : 0;
    if (legal && abort_at == 0) begin
      sched_val  = ref_result(o, a, b);
      sched_edge = k + lat;
    end
    if (abort_at > 0)  n = abort_at;
    else if (legal)    n = lat + 1 + extra;
    else               n = extra;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1 && change_a) bus.A = ~a;
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    bus.op    = 3'b000;
    bus.start = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_result", {16'b0, bus.result}, 32'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // add with start held well past done
    run_op(3'd1, 8'hFF, 8'hFF, 5, 0, 1'b0);
    chk("add_ff_ff", {16'b0, bus.result}, 32'h01FE);

    // multiplies, including operand change after acceptance
    run_op(3'd4, 8'hFF, 8'hFF, 0, 0, 1'b0);
    chk("mul_ff_ff", {16'b0, bus.result}, 32'hFE01);
    run_op(3'd4, 8'h00, 8'h55, 0, 0, 1'b1);
    chk("mul_00_55", {16'b0, bus.result}, 32'h0000);
    run_op(3'd4, 8'h03, 8'h05, 2, 0, 1'b1);
    chk("mul_03_05", {16'b0, bus.result}, 32'h000F);

    // logic ops, upper byte zero
    run_op(3'd2, 8'hA5, 8'h3C, 0, 0, 1'b0);
    chk("and_a5_3c", {16'b0, bus.result}, 32'h0024);
    run_op(3'd3, 8'hA5, 8'h5A, 0, 0, 1'b0);
    chk("xor_a5_5a", {16'b0, bus.result}, 32'h00FF);

    // ignored opcodes
    run_op(3'd0, 8'h12, 8'h34, 5, 0, 1'b0);
    chk("noop_keep", {16'b0, bus.result}, 32'h00FF);
    run_op(3'd7, 8'h12, 8'h34, 5, 0, 1'b0);
    chk("op7_keep", {16'b0, bus.result}, 32'h00FF);
    run_op(3'd5, 8'h77, 8'h88, 3, 0, 1'b0);
    chk("op5_keep", {16'b0, bus.result}, 32'h00FF);

    // abandoned multiplies, then a normal add
    run_op(3'd4, 8'h10, 8'h10, 0, 1, 1'b0);
    chk("abort_mul1", {16'b0, bus.result}, 32'h00FF);
    run_op(3'd4, 8'h10, 8'h10, 0, 2, 1'b0);
    chk("abort_mul2", {16'b0, bus.result}, 32'h00FF);
    run_op(3'd1, 8'h01, 8'h02, 0, 0, 1'b0);
    chk("add_01_02", {16'b0, bus.result}, 32'h0003);

    // asynchronous reset while in MUL2
    @(negedge clk);
    bus.op    = 3'd4;
    bus.A     = 8'h07;
    bus.B     = 8'h09;
    bus.start = 1'b1;
    @(posedge clk);  // accept -> MUL1
    @(posedge clk);  // -> MUL2
    #2;
    reset_n    = 1'b0;
    sched_edge = -1;
    model_res  = 16'h0000;
    #1;
    chk("rst_async_done", {31'b0, bus.done}, 32'd0);
    chk("rst_async_result", {16'b0, bus.result}, 32'h0000);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(3'd4, 8'h02, 8'h03, 0, 0, 1'b0);
    chk("mul_after_reset", {16'b0, bus.result}, 32'h0006);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
